eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer.sv | 155 +++++++++++++++
 tb/tb_eth_tx_framer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: adds preamble/SFD, zero-pads short payloads, appends a
// reflected CRC-32 FCS and holds the inter-frame gap before the next frame.
module eth_tx_framer #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_PAYLOAD  = 60,
   parameter int IFG_LEN      = 12,
   parameter int CNT_W        = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_tdata,
   input  logic       s_tvalid,
   input  logic       s_tlast,
   output logic       s_tready,
   output logic [7:0] gmii_txd,
   output logic       gmii_tx_en,
   output logic       gmii_tx_er,
   output logic       frame_done,
   output logic       underrun
);

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG} state_t;

   localparam int                 AUX_W       = 16;
   localparam logic [AUX_W-1:0]   PRE_LAST    = AUX_W'(PREAMBLE_LEN - 1);
   localparam logic [AUX_W-1:0]   IFG_LAST    = AUX_W'(IFG_LEN - 1);
   localparam logic [CNT_W:0]     MIN_W       = (CNT_W + 1)'(MIN_PAYLOAD);
   localparam state_t             AFTER_FRAME = (IFG_LEN > 0) ? IFG : IDLE;

   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++)
         c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   state_t           state_q;
   logic [31:0]      crc_q, crc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AUX_W-1:0] aux_q;
   logic [7:0]       txd_q;
   logic             tx_en_q, tx_er_q, done_q, underrun_q;
   logic [7:0]       byte_in;
   logic [3:0][7:0]  fcs;

   // Pad bytes enter the CRC as zeros; otherwise the accepted input byte.
   always_comb begin
      byte_in = (state_q == PAD) ? 8'h00 : s_tdata;
      crc_d   = crc32_byte(crc_q, byte_in);
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   end

   assign fcs = ~crc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         crc_q      <= '1;
         cnt_q      <= '0;
         aux_q      <= '0;
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         // NOTE: outputs default to idle every cycle (non-blocking, so the
         // state arms below simply override); nothing is left to hold a value.
         txd_q      <= 8'h00;
         tx_en_q    <= 1'b0;
         tx_er_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               crc_q <= '1;
               cnt_q <= '0;
               aux_q <= '0;
               if (s_tvalid) state_q <= PRE;
            end
            PRE: begin
               txd_q   <= 8'h55;
               tx_en_q <= 1'b1;
               if (aux_q == PRE_LAST) begin
                  aux_q   <= '0;
                  state_q <= SFD;
               end else begin
                  aux_q <= aux_q + 1'b1;
               end
            end
            SFD: begin
               txd_q   <= 8'hD5;
               tx_en_q <= 1'b1;
               state_q <= DATA;
            end
            DATA: begin
               tx_en_q <= 1'b1;
               if (s_tvalid) begin
                  txd_q <= s_tdata;
                  crc_q <= crc_d;
                  cnt_q <= cnt_d;
                  if (s_tlast) state_q <= ({1'b0, cnt_d} < MIN_W) ? PAD : FCS;
               end else begin
                  // Starved mid-frame: one errored byte, then flush the rest.
                  tx_er_q    <= 1'b1;
                  underrun_q <= 1'b1;
                  state_q    <= DROP;
               end
            end
            PAD: begin
               tx_en_q <= 1'b1;
               crc_q   <= crc_d;
               cnt_q   <= cnt_d;
               if ({1'b0, cnt_d} >= MIN_W) state_q <= FCS;
            end
            FCS: begin
               txd_q   <= fcs[aux_q[1:0]];
               tx_en_q <= 1'b1;
               if (aux_q[1:0] == 2'd3) begin
                  done_q  <= 1'b1;
                  aux_q   <= '0;
                  state_q <= AFTER_FRAME;
               end else begin
                  aux_q <= aux_q + 1'b1;
               end
            end
            DROP: begin
               if (s_tvalid && s_tlast) begin
                  aux_q   <= '0;
                  state_q <= AFTER_FRAME;
               end
            end
            IFG: begin
               if (aux_q == IFG_LAST) begin
                  aux_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  aux_q <= aux_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_tready   = (state_q == DATA) || (state_q == DROP);
   assign gmii_txd   = txd_q;
   assign gmii_tx_en = tx_en_q;
   assign gmii_tx_er = tx_er_q;
   assign frame_done = done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected GMII bytes are queued as frames
// are driven and popped by negedge monitors on a default and a no-pad instance.
module tb_eth_tx_framer;

   localparam int PRE_N = 7;
   localparam int MIN_N = 60;
   localparam int IFG_N = 12;

   typedef struct packed {
      logic [7:0] data;
      logic       done;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tdata = 8'h00;
   logic       tvalid = 1'b0;
   logic       tlast = 1'b0;
   logic       sel0 = 1'b0;

   logic [7:0] txd, txd0;
   logic       tx_en, tx_er, ready, done, und;
   logic       tx0_en, tx0_er, ready0, done0, und0;

   exp_t       exp_q[$];
   exp_t       exp0_q[$];
   logic [7:0] pay_q[$];

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_on = 1'b0;
   int  idle_run = 0, en_run = 0, last_gap = -1, last_len = -1;
   int  en_run0 = 0, last_len0 = -1;

   always #5 clk = ~clk;

   eth_tx_framer u_dut (
      .clk        (clk),
      .rst        (rst),
      .s_tdata    (tdata),
      .s_tvalid   (tvalid & ~sel0),
      .s_tlast    (tlast),
      .s_tready   (ready),
      .gmii_txd   (txd),
      .gmii_tx_en (tx_en),
      .gmii_tx_er (tx_er),
      .frame_done (done),
      .underrun   (und)
   );

   eth_tx_framer #(.MIN_PAYLOAD(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .s_tdata    (tdata),
      .s_tvalid   (tvalid & sel0),
      .s_tlast    (tlast),
      .s_tready   (ready0),
      .gmii_txd   (txd0),
      .gmii_tx_en (tx0_en),
      .gmii_tx_er (tx0_er),
      .frame_done (done0),
      .underrun   (und0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Bit-serial reference CRC over payload plus zero pad; returns the FCS word.
   function automatic logic [31:0] fcs_model(input int min_pay);
      logic [31:0] c;
      logic [7:0]  b;
      logic        fb;
      int          total;
      c     = 32'hFFFFFFFF;
      total = (pay_q.size() < min_pay) ? min_pay : pay_q.size();
      for (int i = 0; i < total; i++) begin
         b = (i < pay_q.size()) ? pay_q[i] : 8'h00;
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   task automatic push_e(input bit to0, input logic [7:0] d, input logic dn, input logic er);
      exp_t e;
      e.data = d;
      e.done = dn;
      e.err  = er;
      if (to0) exp0_q.push_back(e);
      else     exp_q.push_back(e);
   endtask

   task automatic push_header(input bit to0);
      for (int i = 0; i < PRE_N; i++) push_e(to0, 8'h55, 1'b0, 1'b0);
      push_e(to0, 8'hD5, 1'b0, 1'b0);
   endtask

   task automatic push_frame(input bit to0, input int min_pay, input int n_fcs);
      logic [31:0] f;
      int          total;
      f     = fcs_model(min_pay);
      total = (pay_q.size() < min_pay) ? min_pay : pay_q.size();
      push_header(to0);
      for (int i = 0; i < total; i++)
         push_e(to0, (i < pay_q.size()) ? pay_q[i] : 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < n_fcs; i++)
         push_e(to0, f[8*i +: 8], i == 3, 1'b0);
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send_byte(input logic [7:0] d, input logic l);
      int n;
      bit acc;
      n      = 0;
      acc    = 1'b0;
      tdata  = d;
      tlast  = l;
      tvalid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = sel0 ? ready0 : ready;
         @(posedge clk);
         n++;
      end
      #1;
      check("s_tready handshake", 32'(acc), 32'd1);
   endtask

   task automatic send_frame();
      for (int i = 0; i < pay_q.size(); i++)
         send_byte(pay_q[i], i == pay_q.size() - 1);
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic new_payload(input int len);
      pay_q.delete();
      for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
   endtask

   task automatic wait_done(input bit on0, input int budget);
      int n;
      bit busy;
      n    = 0;
      busy = 1'b1;
      while (busy && n < budget) begin
         @(negedge clk);
         #1;
         busy = on0 ? (exp0_q.size() != 0 || tx0_en) : (exp_q.size() != 0 || tx_en);
         n++;
      end
      check(on0 ? "no-pad frame drained" : "frame drained", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         if (tx_en) begin
            if (en_run == 0) last_gap = idle_run;
            en_run++;
            idle_run = 0;
            if (exp_q.size() == 0) begin
               check("tx_en with nothing expected", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("er/underrun/done/txd", {21'd0, tx_er, und, done, txd},
                     {21'd0, e.err, e.err, e.done, e.data});
            end
         end else begin
            if (en_run != 0) last_len = en_run;
            en_run = 0;
            idle_run++;
            check("idle er/done/underrun", {29'd0, tx_er, done, und}, 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (mon_on) begin
         if (tx0_en) begin
            en_run0++;
            if (exp0_q.size() == 0) begin
               check("no-pad tx_en with nothing expected", 32'd1, 32'd0);
            end else begin
               e = exp0_q.pop_front();
               check("no-pad er/underrun/done/txd", {21'd0, tx0_er, und0, done0, txd0},
                     {21'd0, e.err, e.err, e.done, e.data});
            end
         end else if (en_run0 != 0) begin
            last_len0 = en_run0;
            en_run0   = 0;
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ref_fcs;
      int          lens[3];

      repeat (2) @(posedge clk);
      #1;
      check("reset outputs", {18'd0, txd, tx_en, tx_er, ready, done, und}, 32'd0);
      check("reset outputs no-pad", {18'd0, txd0, tx0_en, tx0_er, ready0, done0, und0}, 32'd0);
      rst    = 1'b0;
      mon_on = 1'b1;
      @(posedge clk);
      #1;

      // "123456789" through the no-pad instance; FCS is the well-known check value.
      sel0 = 1'b1;
      pay_q.delete();
      for (int i = 0; i < 9; i++) pay_q.push_back(8'h31 + 8'(i));
      ref_fcs = 32'hCBF43926;
      push_header(1'b1);
      for (int i = 0; i < 9; i++) push_e(1'b1, pay_q[i], 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push_e(1'b1, ref_fcs[8*i +: 8], i == 3, 1'b0);
      send_frame();
      wait_done(1'b1, 200);
      check("no-pad tx_en length", 32'(last_len0), 32'd21);
      sel0 = 1'b0;

      // Single zero byte: padded to 60, tx_en spans 7+1+60+4 cycles.
      pay_q.delete();
      pay_q.push_back(8'h00);
      push_frame(1'b0, MIN_N, 4);
      send_frame();
      wait_done(1'b0, 300);
      check("1-byte frame tx_en length", 32'(last_len), 32'd72);

      // Back-to-back 64-byte frames with s_tvalid never dropping.
      new_payload(64);
      push_frame(1'b0, MIN_N, 4);
      send_frame();
      new_payload(64);
      push_frame(1'b0, MIN_N, 4);
      send_frame();
      wait_done(1'b0, 300);
      check("back-to-back gap", 32'(last_gap), 32'(IFG_N + 1));
      check("64-byte frame tx_en length", 32'(last_len), 32'd76);

      // Underrun after byte 10 of 20; the next frame waits for drop + IFG + idle.
      new_payload(20);
      push_header(1'b0);
      for (int i = 0; i < 10; i++) push_e(1'b0, pay_q[i], 1'b0, 1'b0);
      push_e(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) send_byte(pay_q[i], 1'b0);
      tvalid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 10; i < 20; i++) send_byte(pay_q[i], i == 19);
      new_payload(30);
      push_frame(1'b0, MIN_N, 4);
      send_frame();
      wait_done(1'b0, 400);
      check("gap after underrun", 32'(last_gap), 32'(10 + IFG_N + 1));

      // Reset while the second FCS byte is on the wire.
      new_payload(64);
      push_frame(1'b0, MIN_N, 2);
      send_frame();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post-reset tx_en/er/ready", {29'd0, tx_en, tx_er, ready}, 32'd0);
      check("cut frame fully seen", 32'(exp_q.size()), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      new_payload(45);
      push_frame(1'b0, MIN_N, 4);
      send_frame();
      wait_done(1'b0, 300);
      check("gap after reset (no IFG)", 32'(last_gap), 32'd3);

      // Padding boundaries, then random lengths with random idle between frames.
      lens = '{59, 60, 61};
      for (int i = 0; i < 9; i++) begin
         if (i < 3)       new_payload(lens[i]);
         else if (i % 2)  new_payload(int'($urandom_range(1, 80)));
         else             new_payload(int'($urandom_range(1, 1500)));
         push_frame(1'b0, MIN_N, 4);
         send_frame();
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
      end
      wait_done(1'b0, 3000);

      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      check("no-pad scoreboard empty", 32'(exp0_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
